// File: rtl/mem_cof_arb.sv
// Coefficient SRAM arbiter: shares one single-port SRAM among NUM_CH requesters
// and routes each read's data back to its issuer through a tag pipeline.
module mem_cof_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CH     = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arb_en,
    input  logic                         sys_pri,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_wr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]            ch_gnt,
    output logic [NUM_CH-1:0]            ch_rvalid,
    output logic [DATA_WIDTH-1:0]        ch_rdata,
    output logic                         mem_cen_n,
    output logic                         mem_wen_n,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);
    localparam int ID_W   = $clog2(NUM_CH);
    localparam int PIPE_D = RD_LATENCY + 1;

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_CH];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_addr[gi]  = ch_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = ch_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [ID_W-1:0]       r_rr_ptr;
    logic                  r_cen_n;
    logic                  r_wen_n;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [PIPE_D-1:0]     r_tag_vld;
    logic [ID_W-1:0]       r_tag_id [PIPE_D];
    logic [NUM_CH-1:0]     r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_gnt_any;
    logic [ID_W-1:0]       w_gnt_id;
    logic [ID_W-1:0]       w_cand;
    logic                  w_gnt_rd;
    int                    w_sum;

    // Candidate order is index order in fixed-priority mode, otherwise a
    // rotation starting at the round-robin pointer; first requester wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_cand    = '0;
        w_sum     = 0;
        if (rst_n && arb_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sys_pri) begin
                    w_sum = k;
                end else begin
                    w_sum = int'(r_rr_ptr) + k;
                    if (w_sum >= NUM_CH) w_sum = w_sum - NUM_CH;
                end
                w_cand = ID_W'(w_sum);
                if (!w_gnt_any && ch_req[w_cand]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = w_cand;
                end
            end
        end
    end

    always_comb begin
        ch_gnt = '0;
        if (w_gnt_any) ch_gnt[w_gnt_id] = 1'b1;
    end

    assign w_gnt_rd = w_gnt_any & ~ch_wr[w_gnt_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_cen_n   <= 1'b1;
            r_wen_n   <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tag_vld <= '0;
            for (int i = 0; i < PIPE_D; i++) r_tag_id[i] <= '0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_gnt_any) begin
                r_rr_ptr <= (w_gnt_id == ID_W'(NUM_CH - 1)) ? '0 : w_gnt_id + ID_W'(1);
                r_cen_n  <= 1'b0;
                r_wen_n  <= ~ch_wr[w_gnt_id];
                r_addr   <= w_addr[w_gnt_id];
                r_wdata  <= w_wdata[w_gnt_id];
            end else begin
                r_cen_n  <= 1'b1;
                r_wen_n  <= 1'b1;
            end
            // Writes enter the pipe as bubbles so returns stay aligned with issue order.
            r_tag_vld   <= {r_tag_vld[PIPE_D-2:0], w_gnt_rd};
            r_tag_id[0] <= w_gnt_id;
            for (int i = 1; i < PIPE_D; i++) r_tag_id[i] <= r_tag_id[i-1];
            r_rvalid <= '0;
            if (r_tag_vld[PIPE_D-1]) begin
                r_rvalid[r_tag_id[PIPE_D-1]] <= 1'b1;
                r_rdata                      <= mem_rdata;
            end
        end
    end

    assign mem_cen_n = r_cen_n;
    assign mem_wen_n = r_wen_n;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign ch_rvalid = r_rvalid;
    assign ch_rdata  = r_rdata;
endmodule
